// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. It owns the PC, drives the instruction-memory
// request, and handles hazard-unit stall/flush and branch/jump redirects.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    output logic        o_ifid_valid,
    output logic [31:0] o_ifid_pc,
    output logic [31:0] o_ifid_pc_plus4,
    output logic [31:0] o_ifid_instr,
    output logic [24:0] o_imm_bits,
    output logic        o_fetch_busy,
    output logic [1:0]  o_dbg_state
);

    // Memory handshake: o_imem_req/o_imem_addr stay stable from assertion until a cycle in which
    // i_imem_ready is high; that cycle completes the request and i_imem_rdata is sampled.
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] tgt_q, tgt_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = {i_redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        tgt_d        = tgt_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;

        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (i_redirect) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    buf_d        = NOP_INSTR;
                    if (!i_imem_ready) begin
                        tgt_d   = redirect_pc;
                        state_d = S_DROP;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (i_imem_ready) begin
                    if (!i_stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_pc4_d   = pc_plus4;
                        ifid_instr_d = i_imem_rdata;
                        pc_d         = pc_plus4;
                    end else begin
                        buf_d   = i_imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (i_redirect) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    buf_d        = NOP_INSTR;
                    pc_d         = redirect_pc;
                    state_d      = S_FETCH;
                end else if (!i_stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_q;
                    ifid_pc4_d   = pc_plus4;
                    ifid_instr_d = buf_q;
                    pc_d         = pc_plus4;
                    state_d      = S_FETCH;
                end
            end
            S_DROP: begin
                // The stale request must still complete; only then does fetch restart at the target.
                if (i_redirect) begin
                    tgt_d = redirect_pc;
                end
                if (i_imem_ready) begin
                    pc_d    = i_redirect ? redirect_pc : tgt_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_BOOT;
        endcase

        if (i_flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            buf_q        <= NOP_INSTR;
            tgt_q        <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            tgt_q        <= tgt_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign o_imem_req      = (state_q == S_FETCH) || (state_q == S_DROP);
    assign o_imem_addr     = {pc_q[31:2], 2'b00};
    assign o_fetch_busy    = o_imem_req && !i_imem_ready;
    assign o_ifid_valid    = ifid_valid_q;
    assign o_ifid_pc       = ifid_pc_q;
    assign o_ifid_pc_plus4 = ifid_pc4_q;
    assign o_ifid_instr    = ifid_instr_q;
    assign o_imm_bits      = ifid_instr_q[31:7];
    assign o_dbg_state     = state_q;

endmodule
